parity_tx_stage: RTL and testbench

PARITY_TX_STAGE -- requirements
Module: parity_tx_stage

---
 rtl/parity_tx_stage.sv | 163 ++++++++++++++++
 tb/tb_parity_tx_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_tx_stage.sv
// Parity-encoding transmit stage: a 2-entry skid buffer that appends one parity bit per word.
// Optional error injection is enabled by defining PARITY_TX_ERR_INJECT_EN.
module parity_tx_stage #(
  parameter int   DATA_WIDTH = 17,
  parameter logic PARITY     = 1'b1,
  parameter logic P_BIT      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  grant_out,
  input  logic [DATA_WIDTH-2:0] data_in,
  output logic                  valid_out,
  input  logic                  grant_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  inject_err,
  output logic [15:0]           tx_count
);

  localparam int PW = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Parity is the XOR-reduction of the payload, inverted for odd sense, optionally flipped.
  function automatic logic [DATA_WIDTH-1:0] encode(input logic [PW-1:0] d, input logic flip);
    logic p;
    p = (^d) ^ (~PARITY) ^ flip;
    if (P_BIT) begin
      encode = {d, p};
    end else begin
      encode = {p, d};
    end
  endfunction

  state_t                state_r;
  state_t                state_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic                  grant_r;
  logic                  valid_r;
  logic [15:0]           count_r;

  logic                  in_xfer_s;
  logic                  out_xfer_s;
  logic                  flip_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  load_head_s;
  logic                  head_from_skid_s;
  logic                  load_skid_s;

  assign in_xfer_s  = valid_in & grant_r;
  assign out_xfer_s = valid_r & grant_in;
  assign word_s     = encode(data_in, flip_s);

`ifdef PARITY_TX_ERR_INJECT_EN
  logic pend_r;

  assign flip_s = inject_err | pend_r;

  // A request seen without an accepted word waits here for the next accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 1'b0;
    end else if (in_xfer_s) begin
      pend_r <= 1'b0;
    end else if (inject_err) begin
      pend_r <= 1'b1;
    end else begin
      pend_r <= pend_r;
    end
  end
`else
  logic unused_inject_s;

  assign flip_s          = 1'b0;
  assign unused_inject_s = inject_err;
`endif

  // Next state and datapath steering for the skid buffer.
  always_comb begin
    state_s          = state_r;
    load_head_s      = 1'b0;
    head_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_xfer_s) begin
          state_s     = ONE;
          load_head_s = 1'b1;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          state_s     = ONE;
          load_head_s = 1'b1;
        end else if (in_xfer_s) begin
          state_s     = TWO;
          load_skid_s = 1'b1;
        end else if (out_xfer_s) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      TWO: begin
        if (out_xfer_s) begin
          state_s          = ONE;
          head_from_skid_s = 1'b1;
        end else begin
          state_s = TWO;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // State, handshake flags, storage and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
      grant_r <= 1'b0;
      valid_r <= 1'b0;
      head_r  <= {DATA_WIDTH{1'b0}};
      skid_r  <= {DATA_WIDTH{1'b0}};
      count_r <= 16'd0;
    end else begin
      state_r <= state_s;
      grant_r <= (state_s != TWO);
      valid_r <= (state_s != EMPTY);
      if (load_head_s) begin
        head_r <= word_s;
      end else if (head_from_skid_s) begin
        head_r <= skid_r;
      end else begin
        head_r <= head_r;
      end
      if (load_skid_s) begin
        skid_r <= word_s;
      end else begin
        skid_r <= skid_r;
      end
      if (out_xfer_s) begin
        count_r <= count_r + 16'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign grant_out = grant_r;
  assign valid_out = valid_r;
  assign data_out  = head_r;
  assign tx_count  = count_r;

endmodule

// File: tb/tb_parity_tx_stage.sv
// Self-checking bench for parity_tx_stage: queue-based model checked every cycle, plus literal vectors.
module tb_parity_tx_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_in, grant_in, inject_err;
  logic [15:0] data_in;

  logic        grant_out, valid_out;
  logic [16:0] data_out;
  logic [15:0] tx_count;
  logic        grant_out_m, valid_out_m;
  logic [16:0] data_out_m;
  logic [15:0] tx_count_m;
  logic        grant_out_o, valid_out_o;
  logic [16:0] data_out_o;
  logic [15:0] tx_count_o;

  parity_tx_stage #(.DATA_WIDTH(17), .PARITY(1'b1), .P_BIT(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .grant_out(grant_out), .data_in(data_in),
    .valid_out(valid_out), .grant_in(grant_in), .data_out(data_out), .inject_err(inject_err),
    .tx_count(tx_count));

  parity_tx_stage #(.DATA_WIDTH(17), .PARITY(1'b1), .P_BIT(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .grant_out(grant_out_m), .data_in(data_in),
    .valid_out(valid_out_m), .grant_in(grant_in), .data_out(data_out_m), .inject_err(inject_err),
    .tx_count(tx_count_m));

  parity_tx_stage #(.DATA_WIDTH(17), .PARITY(1'b0), .P_BIT(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .valid_in(valid_in), .grant_out(grant_out_o), .data_in(data_in),
    .valid_out(valid_out_o), .grant_in(grant_in), .data_out(data_out_o), .inject_err(inject_err),
    .tx_count(tx_count_o));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected word from the parity rules: count ones, pick sense, place the bit.
  function automatic logic [16:0] model_enc(input logic [15:0] d, input bit flip,
                                            input bit even, input bit lsb);
    int ones;
    int p;
    ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(d[i]);
    p = ones % 2;
    if (!even) p = 1 - p;
    if (flip) p = 1 - p;
    if (lsb) return ({1'b0, d} * 17'd2) + 17'(p);
    else return {1'b0, d} + (17'(p) << 16);
  endfunction

  typedef struct {
    logic [15:0] d;
    bit          flip;
  } entry_t;

  entry_t      q[$];
  logic [15:0] m_cnt   = 16'd0;
  bit          m_grant = 1'b0;
  bit          m_flag  = 1'b0;
  bit          chk_en  = 1'b0;

  // Model: FIFO of at most two payloads, updated with the values present before each edge.
  always @(posedge clk) begin : model
    bit     in_x;
    bit     out_x;
    entry_t e;
    if (rst) begin
      q.delete();
      m_cnt   = 16'd0;
      m_grant = 1'b0;
      m_flag  = 1'b0;
    end else begin
      in_x  = valid_in && m_grant;
      out_x = (q.size() > 0) && grant_in;
      if (out_x) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (in_x) begin
        e.d    = data_in;
`ifdef PARITY_TX_ERR_INJECT_EN
        e.flip = inject_err || m_flag;
        m_flag = 1'b0;
`else
        e.flip = 1'b0;
`endif
        q.push_back(e);
      end else begin
`ifdef PARITY_TX_ERR_INJECT_EN
        if (inject_err) m_flag = 1'b1;
`endif
      end
      m_grant = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_out", 64'(valid_out), 64'(q.size() > 0));
      chk("grant_out", 64'(grant_out), 64'(m_grant));
      chk("tx_count", 64'(tx_count), 64'(m_cnt));
      chk("msb_valid_out", 64'(valid_out_m), 64'(q.size() > 0));
      chk("odd_tx_count", 64'(tx_count_o), 64'(m_cnt));
      if (q.size() > 0) begin
        chk("data_out", 64'(data_out), 64'(model_enc(q[0].d, q[0].flip, 1'b1, 1'b1)));
        chk("msb_data_out", 64'(data_out_m), 64'(model_enc(q[0].d, q[0].flip, 1'b1, 1'b0)));
        chk("odd_data_out", 64'(data_out_o), 64'(model_enc(q[0].d, q[0].flip, 1'b0, 1'b1)));
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [15:0] d,
                      input logic g, input logic inj);
    rst        = r;
    valid_in   = v;
    data_in    = d;
    grant_in   = g;
    inject_err = inj;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = 16'h0; grant_in = 1'b0; inject_err = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("reset_valid", 64'(valid_out), 64'h0);
    chk("reset_grant", 64'(grant_out), 64'h0);
    chk("reset_data", 64'(data_out), 64'h0);
    chk("reset_tx", 64'(tx_count), 64'h0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("grant_after_reset", 64'(grant_out), 64'h1);

    // Encoding vectors for all three parameter sets
    step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    chk("enc_even_lsb", 64'(data_out), 64'h00003);
    chk("enc_even_msb", 64'(data_out_m), 64'h10001);
    chk("enc_odd_lsb_1", 64'(data_out_o), 64'h00002);
    chk("latency_valid", 64'(valid_out), 64'h1);
    step(1'b0, 1'b1, 16'h0003, 1'b1, 1'b0);
    chk("enc_even_lsb_3", 64'(data_out), 64'h00006);
    chk("enc_odd_lsb_3", 64'(data_out_o), 64'h00007);
    chk("enc_even_msb_3", 64'(data_out_m), 64'h00003);
    chk("tx_after_overlap", 64'(tx_count), 64'h1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("tx_after_drain", 64'(tx_count), 64'h2);

    // Backpressure: A and B buffered, C held off, then drained in order
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h000A, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h000B, 1'b0, 1'b0);
    chk("full_grant", 64'(grant_out), 64'h0);
    chk("full_head_a", 64'(data_out), 64'h00014);
    step(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
    chk("stall_head_a", 64'(data_out), 64'h00014);
    chk("stall_valid", 64'(valid_out), 64'h1);
    step(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0);
    chk("order_b", 64'(data_out), 64'h00017);
    step(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0);
    chk("order_c", 64'(data_out), 64'h00018);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("backpressure_tx", 64'(tx_count), 64'h3);
    chk("backpressure_empty", 64'(valid_out), 64'h0);

    // Streaming: one word per cycle for 20 cycles
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 16'(i * 37 + 5), 1'b1, 1'b0);
      chk("stream_valid", 64'(valid_out), 64'h1);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("stream_tx", 64'(tx_count), 64'd20);

    // Reset while holding two words
    step(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0);
    chk("two_grant", 64'(grant_out), 64'h0);
    step(1'b1, 1'b1, 16'h3333, 1'b1, 1'b0);
    chk("rst_two_valid", 64'(valid_out), 64'h0);
    chk("rst_two_grant", 64'(grant_out), 64'h0);
    chk("rst_two_tx", 64'(tx_count), 64'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_grant", 64'(grant_out), 64'h1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_no_emit", 64'(valid_out), 64'h0);

    // Error injection: alone (sticky), then on a transfer edge
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
`ifdef PARITY_TX_ERR_INJECT_EN
    chk("inject_sticky", 64'(data_out), 64'h00002);
`else
    chk("inject_ignored", 64'(data_out), 64'h00003);
`endif
    step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    chk("inject_cleared", 64'(data_out), 64'h00003);
    step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
`ifdef PARITY_TX_ERR_INJECT_EN
    chk("inject_same_edge", 64'(data_out), 64'h00002);
`else
    chk("inject_same_edge_ignored", 64'(data_out), 64'h00003);
`endif
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Reset drops a pending injection request
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    chk("inject_dropped_by_rst", 64'(data_out), 64'h00003);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
